i2c_slave_ctrl: RTL and testbench
=================================

// Module: i2c_slave_ctrl
// PURPOSE
//  Transaction sequencer for the I2C slave.
//  - Consumes start/stop/address-match/rw decode flags plus synchronized SCL edge strobes.
//  - Drives shift-register enables, SDA output mode, and the RX/TX FIFO handshakes.
//  - Sits between the bus decode logic and the rx/tx shift registers and FIFOs.
// PARAMETERS
//  BYTE_BITS       8     bits per byte phase before the ACK slot
//  TIMEOUT_CYCLES  4096  clk cycles without an SCL edge before abort (I2C_SLV_TIMEOUT_EN only)
// PORTS
//  clk            in   1  system clock
//  n_rst          in   1  asynchronous, active-low reset
//  start_found    in   1  start/repeated-start condition, 1-cycle strobe
//  stop_found     in   1  stop condition, 1-cycle strobe
//  scl_rise       in   1  SCL rising-edge strobe, synchronized
//  scl_fall       in   1  SCL falling-edge strobe, synchronized
//  sda_in         in   1  synchronized SDA, sampled for master ACK/NACK
//  address_match  in   1  rx shift byte[7:1] equals slave address
//  rw_mode        in   1  rx shift byte[0]; 1 = master read
//  rx_full        in   1  RX FIFO cannot accept a byte
//  tx_empty       in   1  TX FIFO has no data
//  rx_enable      out  1  shift rx register, pulse on scl_rise in address/write phases
//  tx_enable      out  1  shift tx register, pulse on scl_fall in read phase
//  load_data      out  1  load tx register from TX FIFO and pop it, 1-cycle pulse
//  rx_data_valid  out  1  push rx byte into RX FIFO, 1-cycle pulse
//  tx_underrun    out  1  load_data issued while tx_empty, 1-cycle pulse
//  sda_mode       out  2  00 release, 01 drive low (ACK), 10 drive high (NACK), 11 tx bit
//  busy           out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset and IDLE
//  - Reset: state IDLE, bit_cnt 0, all outputs 0.
//  Event priority (every state)
//  - stop_found -> IDLE.
//  - Else start_found -> ADDR_RX with bit_cnt cleared.
//  - Start/stop override any SCL edge in the same cycle.
//  ADDR_RX
//  - rx_enable = scl_rise.
//  - bit_cnt increments per scl_rise; on the BYTE_BITS-th rise -> ADDR_CHK.
//  ADDR_CHK (shift register settled)
//  - On scl_fall: address_match -> ACK_ADDR; else -> WAIT_STOP.
//  ACK_ADDR
//  - sda_mode = 01.
//  - On scl_fall with rw_mode = 0 -> RX_DATA.
//  - On scl_fall with rw_mode = 1 -> TX_DATA: load_data pulses that cycle, sda_mode = 11 from the next cycle.
//  RX_DATA
//  - rx_enable = scl_rise.
//  - After the BYTE_BITS-th rise: rx_data_valid pulses exactly once (next cycle) if !rx_full, then -> RX_ACK.
//  RX_ACK
//  - sda_mode = 01 if the byte was accepted, else 10 (NACK).
//  - On scl_fall -> RX_DATA (accepted) or WAIT_STOP (NACK).
//  TX_DATA
//  - sda_mode = 11.
//  - tx_enable = scl_fall for the first BYTE_BITS-1 falls.
//  - BYTE_BITS-th fall -> TX_MACK, sda_mode 00.
//  TX_MACK
//  - On scl_rise sample sda_in: 0 (ACK) -> TX_LOAD; 1 (NACK) -> WAIT_STOP.
//  TX_LOAD
//  - On scl_fall: load_data pulse -> TX_DATA.
//  - tx_underrun pulses alongside load_data when tx_empty (the byte is still clocked out).
//  WAIT_STOP
//  - sda_mode 00; ignores SCL edges until start/stop.
//  Counter
//  - bit_cnt clears on every state change.
// CONFIGURATION
//  Macro I2C_SLV_TIMEOUT_EN
//  - Defined: idle counter resets on any SCL edge, start, or stop.
//    While busy, reaching TIMEOUT_CYCLES forces IDLE with sda_mode 00.
//  - Undefined: no counter; the FSM waits indefinitely.
// STRUCTURE
//  - Package i2c_slave_pkg: state_t enum, sda_mode_t localparams (SDA_REL, SDA_ACK, SDA_NACK, SDA_TX).
//  - Sub-module i2c_bit_counter: clear/enable/rollover-at-BYTE_BITS counter, instantiated once.
// TESTING
//  1. Reset mid-TX_DATA -> next cycle all outputs 0, busy 0.
//  2. Write, addr 0x78 + W, data 0xA5 -> 8 rx_enable pulses, sda_mode 01 in ACK slot,
//     8 more, rx_data_valid once, ACK, stop -> IDLE.
//  3. Address 0x50 + W (mismatch) -> sda_mode never leaves 00; WAIT_STOP until stop.
//  4. Read, addr 0x78 + R, master ACKs byte 1, NACKs byte 2 -> load_data x2,
//     tx_enable 7 per byte, then WAIT_STOP.
//  5. Write with rx_full = 1 on byte 1 -> no rx_data_valid, sda_mode 10 in ACK slot, WAIT_STOP.
//  6. Repeated start mid-RX_DATA after 3 bits -> ADDR_RX, bit_cnt 0.
//     With I2C_SLV_TIMEOUT_EN: SCL held 4096 cycles -> IDLE.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C slave transaction sequencer: FSM states and SDA output modes.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR_RX   = 4'd1,
        ADDR_CHK  = 4'd2,
        ACK_ADDR  = 4'd3,
        RX_DATA   = 4'd4,
        RX_ACK    = 4'd5,
        TX_DATA   = 4'd6,
        TX_MACK   = 4'd7,
        TX_LOAD   = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    typedef logic [1:0] sda_mode_t;

    localparam sda_mode_t SDA_REL  = 2'b00;
    localparam sda_mode_t SDA_ACK  = 2'b01;
    localparam sda_mode_t SDA_NACK = 2'b10;
    localparam sda_mode_t SDA_TX   = 2'b11;

endpackage

// File: rtl/i2c_bit_counter.sv
// Bit-position counter for one byte phase; wraps to zero and flags rollover on the last bit.
module i2c_bit_counter #(
    parameter int BYTE_BITS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic rollover
);

    localparam int CW = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(BYTE_BITS - 1);

    logic [CW-1:0] count_r;

    // Count enabled SCL edges, restarting at zero after the final bit of the byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            if (count_r == LAST_VAL) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign rollover = enable && (count_r == LAST_VAL);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction sequencer: turns bus events into shift, FIFO and SDA-mode controls.
// Optional bus-idle abort is built when I2C_SLV_TIMEOUT_EN is defined.
module i2c_slave_ctrl
    import i2c_slave_pkg::*;
#(
    parameter int BYTE_BITS = 8
`ifdef I2C_SLV_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       scl_rise,
    input  logic       scl_fall,
    input  logic       sda_in,
    input  logic       address_match,
    input  logic       rw_mode,
    input  logic       rx_full,
    input  logic       tx_empty,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       rx_data_valid,
    output logic       tx_underrun,
    output logic [1:0] sda_mode,
    output logic       busy
);

    state_t    state_r;
    sda_mode_t sda_mode_r;
    logic      rx_enable_r;
    logic      tx_enable_r;
    logic      load_data_r;
    logic      rx_data_valid_r;
    logic      tx_underrun_r;
    logic      busy_r;
    logic      accepted_r;
    logic      ack_slot_r;

    logic      cnt_en_s;
    logic      cnt_clr_s;
    logic      byte_done_s;
    logic      timeout_s;

`ifdef I2C_SLV_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] idle_cnt_r;
    logic          bus_activity_s;

    assign bus_activity_s = start_found || stop_found || scl_rise || scl_fall;

    // Count clk cycles since the last bus event while a transaction is open
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (bus_activity_s || (state_r == IDLE)) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (idle_cnt_r != TW'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    assign timeout_s = !bus_activity_s && (state_r != IDLE) &&
                       (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Select which SCL edge advances the bit counter in the current phase
    always_comb begin
        cnt_en_s = 1'b0;
        if (start_found || stop_found) begin
            cnt_en_s = 1'b0;
        end else begin
            case (state_r)
                ADDR_RX, RX_DATA: cnt_en_s = scl_rise;
                TX_DATA:          cnt_en_s = scl_fall;
                default:          cnt_en_s = 1'b0;
            endcase
        end
    end

    assign cnt_clr_s = start_found || stop_found || timeout_s;

    i2c_bit_counter #(
        .BYTE_BITS (BYTE_BITS)
    ) u_bit_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clr_s),
        .enable   (cnt_en_s),
        .rollover (byte_done_s)
    );

    // Transaction FSM with all control outputs registered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r         <= IDLE;
            sda_mode_r      <= SDA_REL;
            rx_enable_r     <= 1'b0;
            tx_enable_r     <= 1'b0;
            load_data_r     <= 1'b0;
            rx_data_valid_r <= 1'b0;
            tx_underrun_r   <= 1'b0;
            busy_r          <= 1'b0;
            accepted_r      <= 1'b0;
            ack_slot_r      <= 1'b0;
        end else begin
            rx_enable_r     <= 1'b0;
            tx_enable_r     <= 1'b0;
            load_data_r     <= 1'b0;
            rx_data_valid_r <= 1'b0;
            tx_underrun_r   <= 1'b0;
            if (stop_found || timeout_s) begin
                state_r    <= IDLE;
                sda_mode_r <= SDA_REL;
                busy_r     <= 1'b0;
                ack_slot_r <= 1'b0;
            end else if (start_found) begin
                state_r    <= ADDR_RX;
                sda_mode_r <= SDA_REL;
                busy_r     <= 1'b1;
                ack_slot_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ADDR_RX: begin
                        rx_enable_r <= scl_rise;
                        if (byte_done_s) begin
                            state_r <= ADDR_CHK;
                        end
                    end
                    ADDR_CHK: begin
                        if (scl_fall) begin
                            if (address_match) begin
                                state_r    <= ACK_ADDR;
                                sda_mode_r <= SDA_ACK;
                            end else begin
                                state_r    <= WAIT_STOP;
                                sda_mode_r <= SDA_REL;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (scl_fall) begin
                            if (rw_mode) begin
                                state_r       <= TX_DATA;
                                sda_mode_r    <= SDA_TX;
                                load_data_r   <= 1'b1;
                                tx_underrun_r <= tx_empty;
                            end else begin
                                state_r    <= RX_DATA;
                                sda_mode_r <= SDA_REL;
                            end
                        end
                    end
                    RX_DATA: begin
                        rx_enable_r <= scl_rise;
                        if (byte_done_s) begin
                            state_r         <= RX_ACK;
                            accepted_r      <= !rx_full;
                            rx_data_valid_r <= !rx_full;
                            ack_slot_r      <= 1'b0;
                        end
                    end
                    RX_ACK: begin
                        // First fall ends data bit 8 and opens the ACK slot; the second closes it
                        if (scl_fall) begin
                            if (!ack_slot_r) begin
                                ack_slot_r <= 1'b1;
                                sda_mode_r <= accepted_r ? SDA_ACK : SDA_NACK;
                            end else begin
                                ack_slot_r <= 1'b0;
                                sda_mode_r <= SDA_REL;
                                state_r    <= accepted_r ? RX_DATA : WAIT_STOP;
                            end
                        end
                    end
                    TX_DATA: begin
                        if (scl_fall) begin
                            if (byte_done_s) begin
                                state_r    <= TX_MACK;
                                sda_mode_r <= SDA_REL;
                            end else begin
                                tx_enable_r <= 1'b1;
                            end
                        end
                    end
                    TX_MACK: begin
                        if (scl_rise) begin
                            state_r <= sda_in ? WAIT_STOP : TX_LOAD;
                        end
                    end
                    TX_LOAD: begin
                        if (scl_fall) begin
                            state_r       <= TX_DATA;
                            sda_mode_r    <= SDA_TX;
                            load_data_r   <= 1'b1;
                            tx_underrun_r <= tx_empty;
                        end
                    end
                    WAIT_STOP: begin
                        state_r <= WAIT_STOP;
                    end
                    default: begin
                        state_r    <= IDLE;
                        sda_mode_r <= SDA_REL;
                        busy_r     <= 1'b0;
                        ack_slot_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_enable     = rx_enable_r;
    assign tx_enable     = tx_enable_r;
    assign load_data     = load_data_r;
    assign rx_data_valid = rx_data_valid_r;
    assign tx_underrun   = tx_underrun_r;
    assign sda_mode      = sda_mode_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: directed transaction table, hand-written corner sequences and
// randomized transactions scored against a transaction-level expectation model.
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_found = 1'b0;
    logic       stop_found = 1'b0;
    logic       scl_rise = 1'b0;
    logic       scl_fall = 1'b0;
    logic       sda_in = 1'b1;
    logic       address_match = 1'b0;
    logic       rw_mode = 1'b0;
    logic       rx_full = 1'b0;
    logic       tx_empty = 1'b0;
    logic       rx_enable;
    logic       tx_enable;
    logic       load_data;
    logic       rx_data_valid;
    logic       tx_underrun;
    logic [1:0] sda_mode;
    logic       busy;

    always #5 clk = ~clk;

    i2c_slave_ctrl dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start_found   (start_found),
        .stop_found    (stop_found),
        .scl_rise      (scl_rise),
        .scl_fall      (scl_fall),
        .sda_in        (sda_in),
        .address_match (address_match),
        .rw_mode       (rw_mode),
        .rx_full       (rx_full),
        .tx_empty      (tx_empty),
        .rx_enable     (rx_enable),
        .tx_enable     (tx_enable),
        .load_data     (load_data),
        .rx_data_valid (rx_data_valid),
        .tx_underrun   (tx_underrun),
        .sda_mode      (sda_mode),
        .busy          (busy)
    );

    typedef struct {
        bit       rd;
        bit       match;
        int       nbytes;
        bit [3:0] full;
        bit [3:0] nack;
        bit       empty;
        int       e_rx_en;
        int       e_valid;
        int       e_load;
        int       e_tx_en;
        int       e_under;
    } txn_t;

    int n_checks = 0;
    int n_pass = 0;
    int c_rx_en = 0, c_tx_en = 0, c_load = 0, c_valid = 0, c_under = 0, c_drive = 0;

    // Pulse counters sampled on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        c_rx_en += int'(rx_enable);
        c_tx_en += int'(tx_enable);
        c_load  += int'(load_data);
        c_valid += int'(rx_data_valid);
        c_under += int'(tx_underrun);
        c_drive += int'(sda_mode != 2'b00);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input logic r, input logic f, input logic st, input logic sp);
        scl_rise = r; scl_fall = f; start_found = st; stop_found = sp;
        @(posedge clk); #1;
        scl_rise = 1'b0; scl_fall = 1'b0; start_found = 1'b0; stop_found = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic scl_bit();
        tick(1'b1, 1'b0, 1'b0, 1'b0); gap(2);
        tick(1'b0, 1'b1, 1'b0, 1'b0); gap(2);
    endtask

    // Expected pulse counts derived from the protocol: who owns each byte and its ACK slot
    function automatic txn_t model(input txn_t t);
        txn_t m = t;
        m.e_rx_en = 8; m.e_valid = 0; m.e_load = 0; m.e_tx_en = 0; m.e_under = 0;
        if (t.match) begin
            if (!t.rd) begin
                for (int b = 0; b < t.nbytes; b++) begin
                    m.e_rx_en += 8;
                    if (t.full[b]) break;
                    m.e_valid++;
                end
            end else begin
                m.e_load = 1;
                for (int b = 0; b < t.nbytes; b++) begin
                    m.e_tx_en += 7;
                    if (t.nack[b]) break;
                    m.e_load++;
                end
                m.e_under = t.empty ? m.e_load : 0;
            end
        end
        return m;
    endfunction

    task automatic run_txn(input txn_t t, input string tag);
        int rx0 = c_rx_en, tx0 = c_tx_en, ld0 = c_load, va0 = c_valid, un0 = c_under, dr0 = c_drive;
        bit live;
        address_match = t.match; rw_mode = t.rd; tx_empty = t.empty; rx_full = 1'b0; sda_in = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0); gap(2);
        repeat (8) scl_bit();
        check({tag, " addr_ack_mode"}, int'(sda_mode), t.match ? 1 : 0);
        scl_bit();
        live = t.match;
        for (int b = 0; b < t.nbytes; b++) begin
            if (!t.rd) begin
                rx_full = t.full[b];
                repeat (8) scl_bit();
                check({tag, " data_ack_mode"}, int'(sda_mode), live ? (t.full[b] ? 2 : 1) : 0);
                scl_bit();
                if (t.full[b]) live = 1'b0;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (k == 3) check({tag, " tx_mode"}, int'(sda_mode), live ? 3 : 0);
                    scl_bit();
                end
                sda_in = t.nack[b];
                scl_bit();
                sda_in = 1'b1;
                if (t.nack[b]) live = 1'b0;
            end
        end
        check({tag, " busy_before_stop"}, int'(busy), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1); gap(1);
        check({tag, " busy_after_stop"}, int'(busy), 0);
        check({tag, " mode_after_stop"}, int'(sda_mode), 0);
        check({tag, " rx_enable_cnt"}, c_rx_en - rx0, t.e_rx_en);
        check({tag, " rx_valid_cnt"}, c_valid - va0, t.e_valid);
        check({tag, " load_cnt"}, c_load - ld0, t.e_load);
        check({tag, " tx_enable_cnt"}, c_tx_en - tx0, t.e_tx_en);
        check({tag, " underrun_cnt"}, c_under - un0, t.e_under);
        if (!t.match) check({tag, " sda_never_driven"}, c_drive - dr0, 0);
    endtask

    txn_t tbl[7];
    txn_t rt;
    int   base;

    initial begin
        //        rd    match n  full     nack     empty  rx  val ld  tx  un
        tbl[0] = '{1'b0, 1'b1, 1, 4'b0000, 4'b0000, 1'b0, 16, 1, 0, 0,  0};
        tbl[1] = '{1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0, 8,  0, 0, 0,  0};
        tbl[2] = '{1'b1, 1'b1, 2, 4'b0000, 4'b0010, 1'b0, 8,  0, 2, 14, 0};
        tbl[3] = '{1'b0, 1'b1, 1, 4'b0001, 4'b0000, 1'b0, 16, 0, 0, 0,  0};
        tbl[4] = '{1'b0, 1'b1, 3, 4'b0100, 4'b0000, 1'b0, 32, 2, 0, 0,  0};
        tbl[5] = '{1'b1, 1'b1, 1, 4'b0000, 4'b0000, 1'b1, 8,  0, 2, 7,  2};
        tbl[6] = '{1'b1, 1'b0, 1, 4'b0000, 4'b0000, 1'b0, 8,  0, 0, 0,  0};

        gap(2);
        check("reset_outputs", int'({rx_enable, tx_enable, load_data, rx_data_valid,
                                     tx_underrun, sda_mode, busy}), 0);
        n_rst = 1'b1;
        gap(2);
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Start coinciding with an SCL rise: start wins and no shift pulse is issued
        base = c_rx_en;
        address_match = 1'b1; rw_mode = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0); gap(2);
        check("start_over_rise", c_rx_en - base, 0);
        repeat (8) scl_bit();
        check("start_over_rise_ack", int'(sda_mode), 1);
        scl_bit();
        // Repeated start after three data bits must restart the address phase from bit zero
        repeat (3) scl_bit();
        base = c_rx_en;
        tick(1'b0, 1'b0, 1'b1, 1'b0); gap(2);
        repeat (5) scl_bit();
        check("rstart_no_early_ack", int'(sda_mode), 0);
        repeat (3) scl_bit();
        check("rstart_ack", int'(sda_mode), 1);
        check("rstart_rx_cnt", c_rx_en - base, 8);
        tick(1'b0, 1'b1, 1'b0, 1'b1); gap(1);
        check("stop_over_fall", int'(busy), 0);

        // Asynchronous reset in the middle of a read byte
        address_match = 1'b1; rw_mode = 1'b1; tx_empty = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0); gap(2);
        repeat (9) scl_bit();
        repeat (2) scl_bit();
        check("pre_reset_tx_mode", int'(sda_mode), 3);
        n_rst = 1'b0;
        @(negedge clk);
        check("reset_mid_tx", int'({rx_enable, tx_enable, load_data, rx_data_valid,
                                    tx_underrun, sda_mode, busy}), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        gap(2);
        check("post_reset_busy", int'(busy), 0);

        for (int i = 0; i < 24; i++) begin
            rt.rd = 1'($urandom_range(1, 0));
            rt.match = ($urandom_range(4, 0) != 0);
            rt.nbytes = int'($urandom_range(3, 1));
            rt.full = 4'($urandom_range(15, 0)) & {3'b000, 1'($urandom_range(1, 0))} ;
            if ($urandom_range(2, 0) == 0) rt.full = 4'($urandom_range(15, 0));
            rt.nack = 4'($urandom_range(15, 0));
            rt.empty = ($urandom_range(3, 0) == 0);
            rt = model(rt);
            run_txn(rt, $sformatf("rnd%0d", i));
        end

`ifdef I2C_SLV_TIMEOUT_EN
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        gap(4000);
        check("timeout_still_busy", int'(busy), 1);
        gap(200);
        check("timeout_idle", int'(busy), 0);
        check("timeout_mode", int'(sda_mode), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
